// File: rtl/bt_pkg.sv
// Shared types and constants for the HC-05 command controller.
package bt_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_CMD, S_GET_ARG, S_GET_CHK, S_EXEC, S_TX_BYTE, S_TX_WAIT
  } state_t;

  localparam logic [7:0] CMD_QUERY = 8'h01;
  localparam logic [7:0] CMD_OPEN  = 8'h02;
  localparam logic [7:0] CMD_CLOSE = 8'h03;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCHK = 8'hEE;
  localparam logic [7:0] ST_BADCMD = 8'hEF;

  localparam logic [7:0] HDR_RX_DEF = 8'hAA;
  localparam logic [7:0] HDR_TX_DEF = 8'h55;

  function automatic logic is_known(input logic [7:0] code);
    return (code == CMD_QUERY) || (code == CMD_OPEN) || (code == CMD_CLOSE);
  endfunction

endpackage

// File: rtl/bt_timeout_cnt.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, pulses expire at LIMIT.
module bt_timeout_cnt #(
  parameter int unsigned LIMIT = 2400000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (clr || !en)    cnt <= '0;
    else if (cnt != LIM)    cnt <= cnt + W'(1);
  end

  // A clearing byte in the expiry cycle suppresses the pulse.
  assign expire = en && !clr && (cnt == LIM);

endmodule

// File: rtl/bt_cmd_ctrl.sv
// Command frame parser and reply sequencer for the Bluetooth UART link.
module bt_cmd_ctrl
  import bt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2400000,
  parameter logic [7:0]  HDR_RX      = HDR_RX_DEF,
  parameter logic [7:0]  HDR_TX      = HDR_TX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic [7:0] free_slots,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       cmd_vld,
  output logic [7:0] err_cnt
);

  state_t     state, nstate;
  logic [1:0] idx;
  logic       first_wait;
  logic [7:0] cmd_r, arg_r, chk_r, stat_r, tx_byte;
  logic       tmo_en, expire, busy, chk_bad, err_ev;

  assign tmo_en  = (state == S_GET_CMD) || (state == S_GET_ARG) || (state == S_GET_CHK);
  assign busy    = (state == S_EXEC) || (state == S_TX_BYTE) || (state == S_TX_WAIT);
  assign chk_bad = (state == S_EXEC) && ((cmd_r ^ arg_r) != chk_r);
  assign err_ev  = (rx_vld && busy) || chk_bad || expire;

  bt_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (rx_vld),
    .en     (tmo_en),
    .expire (expire)
  );

  always_comb begin
    case (idx)
      2'd0:    tx_byte = HDR_TX;
      2'd1:    tx_byte = cmd_r;
      2'd2:    tx_byte = stat_r;
      default: tx_byte = cmd_r ^ stat_r;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    tx_vld  = 1'b0;
    tx_data = 8'h00;
    case (state)
      S_IDLE:    if (rx_vld && rx_data == HDR_RX) nstate = S_GET_CMD;
      S_GET_CMD: if (rx_vld) nstate = S_GET_ARG; else if (expire) nstate = S_IDLE;
      S_GET_ARG: if (rx_vld) nstate = S_GET_CHK; else if (expire) nstate = S_IDLE;
      S_GET_CHK: if (rx_vld) nstate = S_EXEC;    else if (expire) nstate = S_IDLE;
      S_EXEC:    nstate = S_TX_BYTE;
      S_TX_BYTE: begin
        tx_data = tx_byte;
        if (tx_ready) begin
          tx_vld = 1'b1;
          nstate = S_TX_WAIT;
        end
      end
      S_TX_WAIT: if (!first_wait && tx_ready) nstate = (idx == 2'd3) ? S_IDLE : S_TX_BYTE;
      default:   nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      first_wait <= 1'b0;
      cmd_r      <= '0;
      arg_r      <= '0;
      chk_r      <= '0;
      stat_r     <= '0;
      cmd_code   <= '0;
      cmd_arg    <= '0;
      cmd_vld    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      cmd_vld <= 1'b0;
      case (state)
        S_GET_CMD: if (rx_vld) cmd_r <= rx_data;
        S_GET_ARG: if (rx_vld) arg_r <= rx_data;
        S_GET_CHK: if (rx_vld) begin
          chk_r <= rx_data;
          // Decided on the CHK edge so the pulse and the new code/arg are visible together in EXEC.
          if (((cmd_r ^ arg_r) == rx_data) && is_known(cmd_r)) begin
            cmd_vld  <= 1'b1;
            cmd_code <= cmd_r;
            cmd_arg  <= arg_r;
          end
        end
        S_EXEC: begin
          idx <= '0;
          if (chk_bad)                 stat_r <= ST_BADCHK;
          else if (cmd_r == CMD_QUERY) stat_r <= free_slots;
          else if (is_known(cmd_r))    stat_r <= ST_OK;
          else                         stat_r <= ST_BADCMD;
        end
        S_TX_BYTE: if (tx_ready) first_wait <= 1'b1;
        S_TX_WAIT: begin
          if (first_wait)    first_wait <= 1'b0;
          else if (tx_ready) idx <= idx + 2'd1;
        end
        default: ;
      endcase
      if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed plus randomized frames for bt_cmd_ctrl, checked against a frame-level reference model.
module tb_bt_cmd_ctrl;
  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] free_slots = 8'h00;
  logic [7:0] tx_data, cmd_code, cmd_arg, err_cnt;
  logic       tx_vld, cmd_vld;

  int errors = 0, checks = 0;
  int cyc_n = 0, busy = 0, busy_len = 0, exp_err = 0;
  int cmd_cyc = -1, first_tx_cyc = -1, chk_cyc = 0;
  bit rnd_ready = 1'b0, prev_vld = 1'b0;
  logic [7:0]  txq[$];
  logic [15:0] cmdq[$];

  bt_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_vld(tx_vld),
    .free_slots(free_slots), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .cmd_vld(cmd_vld), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference: reply status and whether a command pulse is due, straight from the frame rules.
  task automatic model(input logic [7:0] c, a, k, fs, output logic [7:0] stat, output bit ok);
    ok = 1'b0;
    if ((c ^ a) != k)              stat = 8'hEE;
    else if (c == 8'h01)           begin stat = fs;    ok = 1'b1; end
    else if (c == 8'h02 || c == 8'h03) begin stat = 8'h00; ok = 1'b1; end
    else                           stat = 8'hEF;
  endtask

  // One clock: drive inputs after the falling edge, then observe what the next rising edge will see.
  task automatic cyc(input bit v, input logic [7:0] d);
    @(negedge clk);
    rx_vld   = v;
    rx_data  = d;
    tx_ready = (busy == 0) && (!rnd_ready || ($urandom_range(3) != 0));
    #1;
    cyc_n++;
    if (tx_vld) begin
      check("tx_vld_while_not_ready", tx_ready, 1);
      check("tx_vld_back_to_back", prev_vld, 0);
      txq.push_back(tx_data);
      if (txq.size() == 1) first_tx_cyc = cyc_n;
      busy = busy_len;
    end else if (busy > 0) busy--;
    prev_vld = tx_vld;
    if (cmd_vld) begin
      cmdq.push_back({cmd_code, cmd_arg});
      cmd_cyc = cyc_n;
    end
  endtask

  task automatic idle_rand();
    repeat ($urandom_range(3)) cyc(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] c, a, k, input int noise, input int gap);
    logic [7:0] n;
    txq.delete(); cmdq.delete();
    cmd_cyc = -1; first_tx_cyc = -1;
    for (int i = 0; i < noise; i++) begin
      n = 8'($urandom);
      if (n == 8'hAA) n = 8'h13;
      cyc(1'b1, n);
    end
    cyc(1'b1, 8'hAA); idle_rand();
    cyc(1'b1, c);
    if (gap >= 0) repeat (gap) cyc(1'b0, 8'h00); else idle_rand();
    cyc(1'b1, a); idle_rand();
    cyc(1'b1, k);
    chk_cyc = cyc_n;
  endtask

  task automatic collect(input logic [7:0] c, a, k, input bit lat);
    logic [7:0] stat, got;
    logic [7:0] exp_b[4];
    bit ok;
    model(c, a, k, free_slots, stat, ok);
    exp_b[0] = 8'h55; exp_b[1] = c; exp_b[2] = stat; exp_b[3] = c ^ stat;
    if ((c ^ a) != k) exp_err = sat(exp_err + 1);
    for (int i = 0; i < 4000 && txq.size() < 4; i++) cyc(1'b0, 8'h00);
    repeat (busy_len + 20) cyc(1'b0, 8'h00);
    check("tx_count", txq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      check($sformatf("tx_byte%0d", i), got, exp_b[i]);
    end
    check("cmd_count", cmdq.size(), ok);
    if (ok && cmdq.size() > 0) check("cmd_code_arg", cmdq[0], {c, a});
    if (lat && ok) check("cmd_latency", cmd_cyc, chk_cyc + 1);
    if (lat) check("tx_latency", first_tx_cyc, chk_cyc + 2);
    check("err_cnt", err_cnt, exp_err);
  endtask

  initial begin
    logic [7:0] c, a, k;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx_vld", tx_vld, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cmd_vld", cmd_vld, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_arg", cmd_arg, 0);
    check("rst_err_cnt", err_cnt, 0);
    reset = 1'b0;

    // Query with latency check
    free_slots = 8'h2A;
    send(8'h01, 8'h00, 8'h01, 0, -1); collect(8'h01, 8'h00, 8'h01, 1'b1);

    // Open gate with a slow transmitter
    busy_len = 50; busy = 50;
    send(8'h02, 8'h05, 8'h07, 0, -1); collect(8'h02, 8'h05, 8'h07, 1'b0);
    busy_len = 0;
    check("cmd_code_held", cmd_code, 8'h02);

    // Bad checksum
    send(8'h03, 8'h00, 8'h00, 0, -1); collect(8'h03, 8'h00, 8'h00, 1'b1);

    // Noise then unknown command
    cyc(1'b1, 8'h13); cyc(1'b1, 8'h37);
    send(8'h09, 8'h01, 8'h08, 0, -1); collect(8'h09, 8'h01, 8'h08, 1'b1);

    // Timeout abort, then a normal frame
    txq.delete(); cmdq.delete();
    cyc(1'b1, 8'hAA); cyc(1'b1, 8'h02);
    repeat (TO + 1) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h05); cyc(1'b1, 8'h07);
    repeat (20) cyc(1'b0, 8'h00);
    exp_err = sat(exp_err + 1);
    check("tmo_no_reply", txq.size(), 0);
    check("tmo_no_cmd", cmdq.size(), 0);
    check("tmo_err_cnt", err_cnt, exp_err);
    send(8'h02, 8'h05, 8'h07, 0, -1); collect(8'h02, 8'h05, 8'h07, 1'b1);

    // Inter-byte gap exactly at the limit is still accepted
    send(8'h03, 8'h44, 8'h47, 0, TO - 1); collect(8'h03, 8'h44, 8'h47, 1'b1);

    // Byte dropped during reply
    busy_len = 10;
    send(8'h01, 8'h7E, 8'h7F, 0, -1);
    for (int i = 0; i < 200 && txq.size() < 1; i++) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h5A);
    exp_err = sat(exp_err + 1);
    collect(8'h01, 8'h7E, 8'h7F, 1'b0);
    busy_len = 0;

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      int r;
      r = $urandom_range(3);
      c = (r == 0) ? 8'($urandom) : 8'(r);
      a = 8'($urandom);
      k = ($urandom_range(3) == 0) ? 8'($urandom) : (c ^ a);
      free_slots = 8'($urandom);
      rnd_ready  = 1'($urandom_range(1));
      busy_len   = $urandom_range(4);
      send(c, a, k, $urandom_range(2), -1);
      collect(c, a, k, !rnd_ready && busy_len == 0);
    end
    rnd_ready = 1'b0;

    // Drop flood drives err_cnt into saturation
    busy_len = 50;
    for (int rd = 0; rd < 3; rd++) begin
      send(8'h02, 8'h01, 8'h03, 0, -1);
      repeat (100) cyc(1'b1, 8'h11);
      exp_err = sat(exp_err + 100);
      collect(8'h02, 8'h01, 8'h03, 1'b0);
    end

    // Reset during reply byte 2
    busy_len = 5;
    send(8'h01, 8'h10, 8'h11, 0, -1);
    for (int i = 0; i < 200 && txq.size() < 2; i++) cyc(1'b0, 8'h00);
    check("pre_rst_tx_count", txq.size(), 2);
    reset = 1'b1;
    #1;
    check("mid_rst_tx_vld", tx_vld, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_cmd_code", cmd_code, 0);
    check("mid_rst_cmd_arg", cmd_arg, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    cyc(1'b0, 8'h00);
    reset = 1'b0;
    exp_err = 0;
    txq.delete();
    repeat (80) cyc(1'b0, 8'h00);
    check("post_rst_no_tx", txq.size(), 0);
    busy_len = 0;
    free_slots = 8'h07;
    send(8'h01, 8'h22, 8'h23, 0, -1); collect(8'h01, 8'h22, 8'h23, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bt_cmd_ctrl.md
Name: bt_cmd_ctrl

Overview:
Command controller for the HC-05 Bluetooth UART link of the parking system. Parses 4-byte command frames from the UART receiver's byte stream and validates them. Issues one command pulse to the park logic for each valid frame. Sequences a 4-byte reply frame into the UART transmitter using a ready/valid byte handshake.

Parameters:
TIMEOUT_CYC, 2400000, max clk cycles allowed between consecutive frame bytes (100 ms at 24 MHz); exceeding it aborts the frame
HDR_RX, 8'hAA, command frame header byte
HDR_TX, 8'h55, reply frame header byte

Ports:
clk  input  1  system clock (24 MHz)
reset  input  1  asynchronous, active-high reset
rx_data  input  8  received byte from UART receiver
rx_vld  input  1  one-cycle pulse, rx_data valid
tx_ready  input  1  high while UART transmitter is idle and can accept a byte
tx_data  output  8  byte to transmit
tx_vld  output  1  one-cycle pulse, load tx_data into transmitter
free_slots  input  8  current free parking count, sampled for query replies
cmd_code  output  8  decoded command, held until next command
cmd_arg  output  8  command argument, held until next command
cmd_vld  output  1  one-cycle pulse per valid, known command
err_cnt  output  8  saturating error count (checksum, timeout, dropped byte)

Behaviour:
- Reset: one clock; asynchronous, active-high reset. On reset, every output is 0, the FSM goes to IDLE, and the timeout counter is cleared. Reset mid-frame or mid-reply abandons the frame with no further tx_vld.
- Frame formats:
  - Command frame: HDR_RX, CMD, ARG, CHK, where CHK = CMD ^ ARG.
  - Reply frame: HDR_TX, CMD, STAT, CMD ^ STAT.
- Commands:
  - 8'h01 query: STAT = free_slots, sampled in the EXEC cycle.
  - 8'h02 open gate: STAT = 8'h00.
  - 8'h03 close gate: STAT = 8'h00.
  - Any other CMD: STAT = 8'hEF; no cmd_vld.
  - Checksum mismatch: STAT = 8'hEE; no cmd_vld; err_cnt +1.
- FSM states: IDLE, GET_CMD, GET_ARG, GET_CHK, EXEC, TX_BYTE, TX_WAIT.
  - IDLE: on rx_vld with rx_data==HDR_RX go to GET_CMD. Other bytes are ignored silently.
  - GET_CMD / GET_ARG / GET_CHK: each rx_vld latches the byte and advances. An inter-byte gap exceeding TIMEOUT_CYC returns to IDLE with err_cnt +1. The counter clears on every accepted byte.
  - EXEC (exactly 1 cycle): evaluate checksum and code, latch STAT, pulse cmd_vld for valid known commands, and update cmd_code/cmd_arg in the same cycle. Byte index = 0.
  - TX_BYTE: wait for tx_ready=1, then assert tx_vld for one cycle with the indexed byte, go to TX_WAIT.
  - TX_WAIT: ignore tx_ready for the first cycle (transmitter latency), then wait for tx_ready=1. Then increment the index; if the index was 3, go to IDLE, else go to TX_BYTE.
- Latency:
  - CHK byte rx_vld at cycle N: EXEC and cmd_vld at N+1.
  - First tx_vld at N+2 if tx_ready is high.
- Byte drops: rx_vld during EXEC/TX_BYTE/TX_WAIT drops the byte with err_cnt +1. No queuing; half-duplex command/response.
- rx_vld and timeout expiry in the same cycle: the byte wins.
- err_cnt saturates at 8'hFF; multiple error events in one cycle count as one.
- tx_vld is never asserted when tx_ready is 0, and never on two consecutive cycles.

Decomposition:
- Shared package bt_pkg: state enum, command codes (CMD_QUERY, CMD_OPEN, CMD_CLOSE), status codes (ST_OK, ST_BADCHK, ST_BADCMD), header constants.
- One natural sub-module: bt_timeout_cnt, an inter-byte watchdog with clear and enable inputs and an expire pulse output.
- Parser and reply sequencer stay in a single FSM.

Test Plan:
- Query: send AA 01 00 01 with free_slots=8'h2A -> cmd_vld pulse with cmd_code=01, cmd_arg=00; tx bytes 55 01 2A 2B.
- Open gate: send AA 02 05 07 -> cmd_vld pulse with cmd_code=02, cmd_arg=05; reply 55 02 00 02. Hold tx_ready low 50 cycles before each byte: exactly 4 tx_vld pulses.
- Bad checksum: send AA 03 00 00 -> no cmd_vld; reply 55 03 EE ED; err_cnt=1.
- Unknown command and noise: send 13 37 then AA 09 01 08 -> leading bytes ignored; no cmd_vld; reply 55 09 EF E6; err_cnt unchanged.
- Timeout: send AA 02, wait TIMEOUT_CYC+1 cycles, then send 05 07 -> err_cnt +1, no reply, no cmd_vld. A following full frame AA 02 05 07 is processed normally.
- Drop and reset: send a byte during reply transmission -> err_cnt +1, reply unchanged. Assert reset during reply byte 2 -> all outputs 0 immediately; after release, IDLE accepts a new frame.
